hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, legal range 1..4: cycles flushD is held after a redirect.
REQ-002 Parameter CNT_W, default 2: width of each per-register pending-write counter (max 2**CNT_W-1 in flight).
REQ-003 clk  in  1  single clock for all state, rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 validD  in  1  decode stage holds a real instruction.
REQ-006 rs1D, rs2D  in  `REG_SIZE each  source register addresses of the decode instruction.
REQ-007 useRs1D, useRs2D  in  1 each  decode instruction actually reads rs1 / rs2.
REQ-008 rdD  in  `REG_SIZE  destination register of the decode instruction.
REQ-009 regWriteD  in  1  decode instruction writes rdD.
REQ-010 regWriteW, writeRegW  in  1, `REG_SIZE  writeback-stage register write strobe and address.
REQ-011 redirectE  in  1  execute stage resolved a taken branch or jump this cycle.
REQ-012 stallF, stallD  out  1 each  hold PC register / decode register.
REQ-013 flushD, flushE  out  1 each  load a bubble into decode register / execute register.
REQ-014 issueD  out  1  decode instruction advances to execute this cycle.
REQ-015 sbErr  out  1  sticky scoreboard error flag.
REQ-016 stallCnt  out  32  count of cycles with stallD asserted, wraps at 2**32.

Function
REQ-017 Scoreboard: one CNT_W-bit counter pend[r] per register r=1..`REG_COUNT-1; register 0 is never tracked and never causes a hazard.
REQ-018 hazard = validD and ((useRs1D and rs1D!=0 and pend[rs1D]!=0) or (useRs2D and rs2D!=0 and pend[rs2D]!=0) or (regWriteD and rdD!=0 and pend[rdD]==max)).
REQ-019 Because the regfile writes on the falling edge, pend[r] is decremented at the rising edge ending the writeback cycle; a source whose only pending write is in W this cycle still counts as hazardous this cycle.
REQ-020 FSM states RUN, STALL, FLUSH; reset state RUN.
REQ-021 RUN -> STALL when hazard and not redirectE; STALL -> RUN when hazard clears; any state -> FLUSH when redirectE (highest priority).
REQ-022 FLUSH holds for exactly FLUSH_CYCLES cycles via a down-counter loaded with FLUSH_CYCLES-1 on redirectE, then -> RUN; a redirectE during FLUSH reloads the counter.
REQ-023 Outputs, combinational from state and inputs: redirectE or state FLUSH -> flushD=1, flushE=1, stallF=0, stallD=0, issueD=0; otherwise hazard -> stallF=1, stallD=1, flushE=1, issueD=0; otherwise issueD=validD, all others 0.
REQ-024 On the rising edge with issueD and regWriteD and rdD!=0: pend[rdD] increments.
REQ-025 On the rising edge with regWriteW and writeRegW!=0: pend[writeRegW] decrements.
REQ-026 Increment and decrement of the same register in the same cycle: count unchanged.
REQ-027 Decrement of a counter already at 0: counter stays 0, sbErr set; sbErr clears only on reset.
REQ-028 Increment is never applied to a counter at max (REQ-018 blocks issue); counters never wrap.
REQ-029 stallCnt increments by 1 on each rising edge where stallD=1.

Reset
REQ-030 While reset is high: all pend=0, state RUN, flush counter 0, sbErr=0, stallCnt=0; with validD=0 and redirectE=0, all 1-bit outputs are 0.
REQ-031 Reset asserted mid-stall or mid-flush abandons the operation; the first cycle after deassertion behaves as RUN with an empty scoreboard.

Verification
REQ-032 Issue x5 write (rdD=5); next cycle use rs1D=5 -> stallD=stallF=flushE=1 until the cycle after regWriteW with writeRegW=5, then issueD=1; stallCnt equals stalled cycles.
REQ-033 Back-to-back writes to x7 (pend[7]=2), then one writeback x7 -> reader of x7 still stalls; second writeback -> reader issues.
REQ-034 redirectE=1 while hazard present, FLUSH_CYCLES=2 -> flushD=flushE=1, stallD=0, issueD=0 for 2 cycles, then normal; no pend change from flushed decode.
REQ-035 Same-cycle issue to x3 and writeback of x3 with pend[3]=1 -> pend[3] stays 1; rs1D=0 with useRs1D=1 never stalls.
REQ-036 regWriteW=1, writeRegW=9 with pend[9]=0 -> sbErr=1, persists until reset; pend[9]=0.
REQ-037 Assert reset during a 3-cycle stall with pend[4]=2 -> outputs 0 immediately, after release a reader of x4 issues without stalling.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard control: per-register pending-write scoreboard, stall/flush FSM
// and stall-cycle counter for an in-order pipeline with a falling-edge register file.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 validD,
    input  logic [`REG_SIZE-1:0] rs1D,
    input  logic [`REG_SIZE-1:0] rs2D,
    input  logic                 useRs1D,
    input  logic                 useRs2D,
    input  logic [`REG_SIZE-1:0] rdD,
    input  logic                 regWriteD,
    input  logic                 regWriteW,
    input  logic [`REG_SIZE-1:0] writeRegW,
    input  logic                 redirectE,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 issueD,
    output logic                 sbErr,
    output logic [31:0]          stallCnt,
    output logic [1:0]           fsmState
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX   = '1;
    localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [1:0]       flushCnt;
    logic [CNT_W-1:0] pend [`REG_COUNT];
    logic             rs1Haz, rs2Haz, rdFull, hazard;

    assign fsmState = state;

    // A write still in W counts as pending: the register file only updates on the falling edge.
    always_comb begin
        rs1Haz = useRs1D && (rs1D != '0) && (pend[rs1D] != '0);
        rs2Haz = useRs2D && (rs2D != '0) && (pend[rs2D] != '0);
        rdFull = regWriteD && (rdD != '0) && (pend[rdD] == PEND_MAX);
        hazard = validD && (rs1Haz || rs2Haz || rdFull);
    end

    // Decode handshake: validD offers an instruction, issueD accepts it this cycle; an
    // instruction not accepted stays in decode (stallD) or is discarded (flushD).
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        issueD = 1'b0;
        if (redirectE || state == FLUSH) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (hazard) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else begin
            issueD = validD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            flushCnt <= '0;
        end else if (redirectE) begin
            state    <= FLUSH;
            flushCnt <= FLUSH_LOAD;
        end else begin
            case (state)
                RUN:     if (hazard) state <= STALL;
                STALL:   if (!hazard) state <= RUN;
                FLUSH: begin
                    if (flushCnt == '0) state <= RUN;
                    else                flushCnt <= flushCnt - 2'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Register 0 is never tracked; its entry stays zero so lookups with index 0 are harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < `REG_COUNT; r++) pend[r] <= '0;
            sbErr <= 1'b0;
        end else begin
            for (int r = 1; r < `REG_COUNT; r++) begin
                logic inc, dec;
                inc = issueD && regWriteD && (rdD == `REG_SIZE'(r));
                dec = regWriteW && (writeRegW == `REG_SIZE'(r));
                if (inc && !dec) begin
                    pend[r] <= pend[r] + 1'b1;
                end else if (dec && !inc) begin
                    if (pend[r] == '0) sbErr <= 1'b1;
                    else               pend[r] <= pend[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       stallCnt <= '0;
        else if (stallD) stallCnt <= stallCnt + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one table record per clock cycle with hand-computed
// outputs, followed by a reset-during-stall sequence.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

module tb_hazard_ctrl;

    typedef struct {
        logic                 v;
        logic [`REG_SIZE-1:0] r1;
        logic                 u1;
        logic [`REG_SIZE-1:0] r2;
        logic                 u2;
        logic [`REG_SIZE-1:0] rd;
        logic                 wd;
        logic                 ww;
        logic [`REG_SIZE-1:0] wr;
        logic                 rdr;
        logic [5:0]           exp;
        logic [31:0]          cnt;
    } vec_t;

    // Expected {stallF, stallD, flushD, flushE, issueD, sbErr}
    localparam logic [5:0] IDL = 6'b000000;
    localparam logic [5:0] ISS = 6'b000010;
    localparam logic [5:0] STL = 6'b110100;
    localparam logic [5:0] FLS = 6'b001100;
    localparam logic [5:0] ERR = 6'b000001;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 validD, useRs1D, useRs2D, regWriteD, regWriteW, redirectE;
    logic [`REG_SIZE-1:0] rs1D, rs2D, rdD, writeRegW;
    logic                 stallF, stallD, flushD, flushE, issueD, sbErr;
    logic [31:0]          stallCnt;
    logic [1:0]           fsmState;

    int n_vec  = 0;
    int n_miss = 0;
    logic [37:0] exp_q[$];
    vec_t tbl[$];

    // clock / reset
    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .validD(validD),
        .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rdD(rdD), .regWriteD(regWriteD), .regWriteW(regWriteW), .writeRegW(writeRegW),
        .redirectE(redirectE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .issueD(issueD), .sbErr(sbErr), .stallCnt(stallCnt), .fsmState(fsmState)
    );

    function automatic vec_t mk(logic v, logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                                logic [4:0] rd, logic wd, logic ww, logic [4:0] wr, logic rdr,
                                logic [5:0] exp, logic [31:0] cnt);
        vec_t t;
        t.v = v; t.r1 = r1; t.u1 = u1; t.r2 = r2; t.u2 = u2; t.rd = rd; t.wd = wd;
        t.ww = ww; t.wr = wr; t.rdr = rdr; t.exp = exp; t.cnt = cnt;
        return t;
    endfunction

    // driver
    task automatic drive(vec_t t);
        validD = t.v; rs1D = t.r1; useRs1D = t.u1; rs2D = t.r2; useRs2D = t.u2;
        rdD = t.rd; regWriteD = t.wd; regWriteW = t.ww; writeRegW = t.wr; redirectE = t.rdr;
    endtask

    // scoreboard compare against the oldest expected entry
    task automatic check(string name);
        logic [37:0] e;
        logic [5:0]  got;
        e   = exp_q.pop_front();
        got = {stallF, stallD, flushD, flushE, issueD, sbErr};
        n_vec++;
        if (got !== e[37:32] || stallCnt !== e[31:0]) begin
            n_miss++;
            $display("FAIL %s: got outs=%b stallCnt=%0d, want outs=%b stallCnt=%0d",
                     name, got, stallCnt, e[37:32], e[31:0]);
        end
    endtask

    task automatic step(vec_t t, string name);
        drive(t);
        exp_q.push_back({t.exp, t.cnt});
        @(negedge clk);
        check(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset block
        reset = 1'b1;
        drive(mk(0,0,0,0,0,0,0,0,0,0,IDL,0));
        @(negedge clk);
        exp_q.push_back({IDL, 32'd0});
        check("reset_outputs");
        n_vec++;
        if (fsmState !== 2'd0) begin
            n_miss++;
            $display("FAIL reset_state: got %0d, want 0", fsmState);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // x5 producer then stalled consumer until writeback retires
        tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,ISS,0));
        tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0,STL,0));
        tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0,STL,1));
        tbl.push_back(mk(1,5,1,0,0,0,0,1,5,0,STL,2));
        tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0,ISS,3));
        // two writes to x7 in flight
        tbl.push_back(mk(1,0,0,0,0,7,1,0,0,0,ISS,3));
        tbl.push_back(mk(1,0,0,0,0,7,1,0,0,0,ISS,3));
        tbl.push_back(mk(1,0,0,7,1,0,0,1,7,0,STL,3));
        tbl.push_back(mk(1,0,0,7,1,0,0,0,0,0,STL,4));
        tbl.push_back(mk(1,0,0,7,1,0,0,1,7,0,STL,5));
        tbl.push_back(mk(1,0,0,7,1,0,0,0,0,0,ISS,6));
        // same-cycle issue and writeback of x3, then x0 sources
        tbl.push_back(mk(1,0,0,0,0,3,1,0,0,0,ISS,6));
        tbl.push_back(mk(1,0,0,0,0,3,1,1,3,0,ISS,6));
        tbl.push_back(mk(1,3,1,0,0,0,0,0,0,0,STL,6));
        tbl.push_back(mk(1,3,1,0,0,0,0,1,3,0,STL,7));
        tbl.push_back(mk(1,0,1,0,1,0,0,0,0,0,ISS,8));
        tbl.push_back(mk(1,3,1,0,0,0,0,0,0,0,ISS,8));
        // x6 saturates at 3 pending writes; a fourth writer must wait
        tbl.push_back(mk(1,0,0,0,0,6,1,0,0,0,ISS,8));
        tbl.push_back(mk(1,0,0,0,0,6,1,0,0,0,ISS,8));
        tbl.push_back(mk(1,0,0,0,0,6,1,0,0,0,ISS,8));
        tbl.push_back(mk(1,0,0,0,0,6,1,0,0,0,STL,8));
        tbl.push_back(mk(1,0,0,0,0,6,1,1,6,0,STL,9));
        tbl.push_back(mk(1,0,0,0,0,6,1,0,0,0,ISS,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,6,0,IDL,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,6,0,IDL,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,6,0,IDL,10));
        // redirect with a hazard present: one redirect cycle plus two FLUSH cycles
        tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,ISS,10));
        tbl.push_back(mk(1,5,1,0,0,8,1,0,0,1,FLS,10));
        tbl.push_back(mk(1,5,1,0,0,8,1,0,0,0,FLS,10));
        tbl.push_back(mk(1,5,1,0,0,8,1,0,0,0,FLS,10));
        tbl.push_back(mk(1,8,1,0,0,0,0,0,0,0,ISS,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,5,0,IDL,10));
        // writeback with nothing pending sets the sticky error
        tbl.push_back(mk(0,0,0,0,0,0,0,1,9,0,IDL,10));
        tbl.push_back(mk(1,9,1,0,0,0,0,0,0,0,ISS|ERR,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,IDL|ERR,10));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of a stall with pend[4]=2
        step(mk(1,0,0,0,0,4,1,0,0,0,ISS|ERR,10), "x4_issue_a");
        step(mk(1,0,0,0,0,4,1,0,0,0,ISS|ERR,10), "x4_issue_b");
        step(mk(1,4,1,0,0,0,0,0,0,0,STL|ERR,10), "x4_stall_1");
        step(mk(1,4,1,0,0,0,0,0,0,0,STL|ERR,11), "x4_stall_2");
        step(mk(1,4,1,0,0,0,0,0,0,0,STL|ERR,12), "x4_stall_3");
        #1;
        reset  = 1'b1;
        validD = 1'b0;
        #1;
        exp_q.push_back({IDL, 32'd0});
        check("reset_mid_stall");
        @(posedge clk);
        #1 reset = 1'b0;
        step(mk(1,4,1,0,0,0,0,0,0,0,ISS,0), "x4_after_reset");
        step(mk(1,4,1,0,0,0,0,0,0,0,ISS,0), "x4_after_reset_2");

        // report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
